// File: rtl/lrf_stream_sched_if.sv
// Stream and pipeline bundle for the LRF frame sequencer.
// Carries the input AXI-stream, the output AXI-stream and the
// enable-gated pipeline hookup so the controller has one bus port.
interface lrf_stream_sched_if #(
    parameter int WORD_WIDTH = 128
);
    // input stream (frame source -> sequencer)
    logic [WORD_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tlast;
    logic                  s_axis_tready;

    // external enable-gated convolution pipeline
    logic                  pipe_en;
    logic [WORD_WIDTH-1:0] pipe_din;
    logic [WORD_WIDTH-1:0] pipe_dout;

    // output stream (sequencer -> consumer)
    logic [WORD_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic [1:0]            m_axis_tuser;

    // sequencer view
    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output pipe_en, pipe_din,
        input  pipe_dout,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        input  m_axis_tready
    );

    // environment view (source, pipeline and consumer)
    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  pipe_en, pipe_din,
        output pipe_dout,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        output m_axis_tready
    );
endinterface

// File: rtl/lrf_stream_sched.sv
// Sequencing controller between the frame source and the enable-gated
// Gaussian pipeline. Takes N_PAIRS interleaved old/new frame pairs,
// advances the pipeline only when a beat enters or a drain bubble is
// needed, and tracks each in-flight beat with a tag that travels in
// lockstep with the pipeline so valid/last/frame-select can be rebuilt
// at the pipeline output.
module lrf_stream_sched #(
    parameter int WORD_WIDTH      = 128,
    parameter int WORDS_PER_IMAGE = 16384,
    parameter int N_PAIRS         = 2,
    parameter int PIPE_LAT        = 4
) (
    input  logic                 s_axis_aclk,
    input  logic                 s_axis_areset,
    input  logic                 start,
    lrf_stream_sched_if.master   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    // counter widths stay at least one bit so single-beat frames and
    // single-pair runs still elaborate cleanly
    localparam int BEAT_W = (WORDS_PER_IMAGE > 1) ? $clog2(WORDS_PER_IMAGE) : 1;
    localparam int PAIR_W = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
    localparam int OCC_W  = $clog2(PIPE_LAT + 1);

    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(WORDS_PER_IMAGE - 1);
    localparam logic [PAIR_W-1:0] PAIR_MAX = PAIR_W'(N_PAIRS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // one tag per pipeline stage describing the word held there
    typedef struct packed {
        logic vld;
        logic sel;
        logic first;
        logic last;
    } tag_t;

    state_t              state_reg;
    logic [BEAT_W-1:0]   beat_cnt_reg;
    logic [PAIR_W-1:0]   pair_cnt_reg;
    logic                sel_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                err_reg;

    tag_t                tag_reg [PIPE_LAT];
    tag_t                tag_in;
    tag_t                tag_out;

    logic                blocked;
    logic                run_ready;
    logic                in_fire;
    logic                pipe_en;
    logic                frame_end;
    logic                tag_first;
    logic                tag_last;
    logic [OCC_W-1:0]    occ;
    logic [OCC_W-1:0]    occ_next;

    // ------------------------------------------------------------------
    // handshake and pipeline enable
    // ------------------------------------------------------------------
    assign tag_out   = tag_reg[PIPE_LAT-1];

    // the output register is the last pipeline stage; when it holds a
    // beat the consumer has not taken, nothing may move
    assign blocked   = tag_out.vld & ~bus.m_axis_tready;
    assign run_ready = (state_reg == ST_RUN) & ~blocked;
    assign in_fire   = bus.s_axis_tvalid & run_ready;
    assign pipe_en   = ~blocked & (in_fire | ((state_reg == ST_DRAIN) & (occ != '0)));

    assign bus.s_axis_tready = run_ready;
    assign bus.pipe_en       = pipe_en;
    assign bus.pipe_din      = in_fire ? bus.s_axis_tdata : '0;

    // output stream rebuilt from the tag riding alongside the word
    assign bus.m_axis_tdata  = bus.pipe_dout;
    assign bus.m_axis_tvalid = tag_out.vld;
    assign bus.m_axis_tlast  = tag_out.vld & tag_out.last;
    assign bus.m_axis_tuser  = tag_out.vld ? {tag_out.first, tag_out.sel} : 2'b00;

    assign busy = busy_reg;
    assign done = done_reg;
    assign err  = err_reg;

    // ------------------------------------------------------------------
    // tag generation for the beat currently offered
    // ------------------------------------------------------------------
    assign frame_end = (beat_cnt_reg == BEAT_MAX);
    assign tag_first = (beat_cnt_reg == '0);
    assign tag_last  = sel_reg & (pair_cnt_reg == PAIR_MAX) & frame_end;

    // build the entry-0 tag: a real beat on in_fire, an all-zero bubble otherwise
    always_comb begin
        tag_in = '0;
        if (in_fire) begin
            tag_in.vld   = 1'b1;
            tag_in.sel   = sel_reg;
            tag_in.first = tag_first;
            tag_in.last  = tag_last;
        end
    end

    // count occupied stages now and after the pending shift
    always_comb begin
        occ      = '0;
        occ_next = '0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            occ = occ + OCC_W'(tag_reg[i].vld);
        end
        occ_next = occ;
        if (pipe_en) begin
            // modular arithmetic keeps this exact even if the
            // intermediate sum briefly wraps
            occ_next = occ + OCC_W'(tag_in.vld) - OCC_W'(tag_out.vld);
        end
    end

    // ------------------------------------------------------------------
    // tag shift register, advanced in lockstep with the pipeline
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                // stage 0 captures the tag of the word entering the pipeline
                always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
                    if (s_axis_areset) begin
                        tag_reg[gi] <= '0;
                    end else if (pipe_en) begin
                        tag_reg[gi] <= tag_in;
                    end
                end
            end else begin : g_body
                // later stages follow the word one pipeline stage down
                always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
                    if (s_axis_areset) begin
                        tag_reg[gi] <= '0;
                    end else if (pipe_en) begin
                        tag_reg[gi] <= tag_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // run sequencing: state, frame counters and status flags
    // ------------------------------------------------------------------
    // run/drain state machine with counters, done pulse and sticky error
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state_reg    <= ST_IDLE;
            beat_cnt_reg <= '0;
            pair_cnt_reg <= '0;
            sel_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg    <= ST_RUN;
                        beat_cnt_reg <= '0;
                        pair_cnt_reg <= '0;
                        sel_reg      <= 1'b0;
                        err_reg      <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (in_fire) begin
                        // source's tlast must agree with our own frame count
                        if (bus.s_axis_tlast != tag_last) begin
                            err_reg <= 1'b1;
                        end
                        if (frame_end) begin
                            beat_cnt_reg <= '0;
                            sel_reg      <= ~sel_reg;
                            // a pair completes when the new frame ends
                            if (sel_reg) begin
                                pair_cnt_reg <= (pair_cnt_reg == PAIR_MAX) ? '0
                                              : pair_cnt_reg + PAIR_W'(1);
                            end
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
                        end
                        if (tag_last) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (occ_next == '0) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lrf_stream_sched.sv
// Bench for lrf_stream_sched. Instance A: 4 beats/frame, 2 pairs,
// 3-stage pipeline. Instance B: 1 beat/frame, 1 pair, 1 stage.
// Expected output beats come from a table computed from the frame
// arithmetic (beat index -> frame select, first, last).
module tb_lrf_stream_sched;

    localparam int WW    = 128;
    localparam int W_A   = 4;
    localparam int N_A   = 2;
    localparam int L_A   = 3;
    localparam int TOT_A = 2 * W_A * N_A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start_a = 1'b0, busy_a, done_a, err_a;
    logic start_b = 1'b0, busy_b, done_b, err_b;

    lrf_stream_sched_if #(.WORD_WIDTH(WW)) a_if();
    lrf_stream_sched_if #(.WORD_WIDTH(WW)) b_if();

    lrf_stream_sched #(
        .WORD_WIDTH(WW), .WORDS_PER_IMAGE(W_A), .N_PAIRS(N_A), .PIPE_LAT(L_A)
    ) dut_a (
        .s_axis_aclk(clk), .s_axis_areset(rst), .start(start_a),
        .bus(a_if), .busy(busy_a), .done(done_a), .err(err_a)
    );

    lrf_stream_sched #(
        .WORD_WIDTH(WW), .WORDS_PER_IMAGE(1), .N_PAIRS(1), .PIPE_LAT(1)
    ) dut_b (
        .s_axis_aclk(clk), .s_axis_areset(rst), .start(start_b),
        .bus(b_if), .busy(busy_b), .done(done_b), .err(err_b)
    );

    // external enable-gated pipelines
    logic [WW-1:0] pa [L_A];
    logic [WW-1:0] pb;
    always @(posedge clk) begin
        if (a_if.pipe_en) begin
            pa[0] <= a_if.pipe_din;
            for (int i = 1; i < L_A; i++) pa[i] <= pa[i-1];
        end
    end
    always @(posedge clk) begin
        if (b_if.pipe_en) pb <= b_if.pipe_din;
    end
    assign a_if.pipe_dout = pa[L_A-1];
    assign b_if.pipe_dout = pb;

    typedef struct {
        logic [WW-1:0] din;
        logic [1:0]    user;
        logic          last;
    } vec_t;
    vec_t vec [TOT_A];

    int n_cmp = 0;
    int n_bad = 0;

    int in_idx, out_idx, cyc, tlast_at;
    int first_in_cyc, first_out_cyc, last_out_cyc, done_cyc;
    bit blk_prev;

    // B sequence bookkeeping
    int            bi, bo, bdone;
    logic [1:0]    bu [2];
    logic          bl [2];
    logic [WW-1:0] bd [2];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // expected beat stream: beat i is frame i/W_A, old/new alternating
    task automatic fill(input bit rnd);
        for (int i = 0; i < TOT_A; i++) begin
            vec[i].din  = rnd ? {$urandom, $urandom, $urandom, $urandom}
                              : {4{32'hC0DE_0000 + 32'(i)}};
            vec[i].user = {((i % W_A) == 0), (((i / W_A) % 2) == 1)};
            vec[i].last = (i == TOT_A - 1);
        end
    endtask

    // one clock of instance A: drive at negedge, observe 1 ns later
    task automatic step_a(input bit vin, input bit rin);
        @(negedge clk);
        a_if.s_axis_tvalid = vin && (in_idx < TOT_A);
        a_if.s_axis_tdata  = (in_idx < TOT_A) ? vec[in_idx].din : '0;
        a_if.s_axis_tlast  = (in_idx == tlast_at);
        a_if.m_axis_tready = rin;
        #1;
        cyc++;
        if (blk_prev) chk("hold_valid", 128'(a_if.m_axis_tvalid), 128'(1));
        if (!a_if.m_axis_tvalid) begin
            chk("bubble_fields", 128'({a_if.m_axis_tuser, a_if.m_axis_tlast}), 128'(0));
        end else if (out_idx < TOT_A) begin
            chk("out_data", a_if.m_axis_tdata, vec[out_idx].din);
            chk("out_user", 128'(a_if.m_axis_tuser), 128'(vec[out_idx].user));
            chk("out_last", 128'(a_if.m_axis_tlast), 128'(vec[out_idx].last));
        end
        if (a_if.m_axis_tvalid && !a_if.m_axis_tready) begin
            chk("blocked_rdy_en", 128'({a_if.s_axis_tready, a_if.pipe_en}), 128'(0));
        end
        if (a_if.m_axis_tvalid && a_if.m_axis_tready && a_if.pipe_en) begin
            if (out_idx >= TOT_A) chk("extra_output", 128'(out_idx + 1), 128'(TOT_A));
            if (out_idx == 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            out_idx++;
        end
        if (a_if.s_axis_tvalid && a_if.s_axis_tready) begin
            chk("pipe_din", a_if.pipe_din, vec[in_idx].din);
            chk("en_on_take", 128'(a_if.pipe_en), 128'(1));
            if (in_idx == 0) first_in_cyc = cyc;
            in_idx++;
        end
        if (done_a) begin
            chk("busy_at_done", 128'(busy_a), 128'(0));
            done_cyc = cyc;
        end
        blk_prev = a_if.m_axis_tvalid && !a_if.m_axis_tready;
    endtask

    // full run on A with tvalid/tready probabilities in percent
    task automatic run_a(input int pv, input int pr, input int hold_at,
                         input int abort_at, input bit lat_chk);
        int hold_cnt;
        bit v, r;
        hold_cnt = 0;
        in_idx = 0; out_idx = 0; cyc = 0; blk_prev = 1'b0;
        first_in_cyc = -1; first_out_cyc = -1; last_out_cyc = -1; done_cyc = -1;
        @(negedge clk);
        a_if.s_axis_tvalid = 1'b0;
        a_if.m_axis_tready = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        #1;
        chk("start_busy", 128'(busy_a), 128'(1));
        chk("start_err_clr", 128'(err_a), 128'(0));
        for (int k = 0; k < 2000 && done_cyc < 0; k++) begin
            if (abort_at >= 0 && in_idx == abort_at) return;
            v = ($urandom_range(99) < pv);
            r = ($urandom_range(99) < pr);
            if (hold_at >= 0 && out_idx >= hold_at && hold_cnt < 10) begin
                r = 1'b0;
                hold_cnt++;
            end
            step_a(v, r);
        end
        chk("done_seen", 128'(done_cyc >= 0), 128'(1));
        chk("out_count", 128'(out_idx), 128'(TOT_A));
        chk("done_after_last", 128'(done_cyc - last_out_cyc), 128'(1));
        chk("err_flag", 128'(err_a), 128'(tlast_at != TOT_A - 1));
        if (lat_chk) chk("first_latency", 128'(first_out_cyc - first_in_cyc), 128'(L_A));
    endtask

    initial begin
        a_if.s_axis_tvalid = 1'b0; a_if.s_axis_tdata = '0; a_if.s_axis_tlast = 1'b0;
        a_if.m_axis_tready = 1'b1;
        b_if.s_axis_tvalid = 1'b0; b_if.s_axis_tdata = '0; b_if.s_axis_tlast = 1'b0;
        b_if.m_axis_tready = 1'b1;
        tlast_at = TOT_A - 1;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs_a", 128'({a_if.s_axis_tready, a_if.pipe_en, a_if.m_axis_tvalid,
                                     a_if.m_axis_tlast, a_if.m_axis_tuser, busy_a, done_a, err_a}), 128'(0));
        chk("reset_outputs_b", 128'({b_if.s_axis_tready, b_if.pipe_en, b_if.m_axis_tvalid,
                                     busy_b, done_b, err_b}), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // continuous flow: pattern, latency, tlast, done
        fill(1'b0);
        run_a(100, 100, -1, -1, 1'b1);

        // random handshakes against the table model
        for (int t = 0; t < 4; t++) begin
            fill(1'b1);
            run_a(50, 50, -1, -1, 1'b0);
        end

        // consumer stalls for 10 cycles mid-run
        fill(1'b0);
        run_a(100, 100, 2, -1, 1'b0);

        // early tlast: sticky err, cleared by the next start
        tlast_at = 7;
        run_a(100, 100, -1, -1, 1'b0);
        repeat (3) step_a(1'b0, 1'b1);
        chk("err_sticky", 128'(err_a), 128'(1));
        tlast_at = TOT_A - 1;
        fill(1'b1);
        run_a(100, 100, -1, -1, 1'b0);

        // reset mid-run at beat 6
        fill(1'b0);
        run_a(100, 100, -1, 6, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrun_reset", 128'({a_if.s_axis_tready, a_if.pipe_en, a_if.m_axis_tvalid,
                                  a_if.m_axis_tlast, a_if.m_axis_tuser, busy_a, done_a, err_a}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        a_if.s_axis_tvalid = 1'b0;
        fill(1'b1);
        run_a(100, 100, -1, -1, 1'b1);

        // single-beat frames, one pair, one stage; start during RUN ignored
        bi = 0; bo = 0; bdone = -1;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 30 && bdone < 0; k++) begin
            @(negedge clk);
            b_if.s_axis_tvalid = (bi < 2);
            b_if.s_axis_tdata  = {96'h0, 32'hB000_0000 + 32'(bi)};
            b_if.s_axis_tlast  = (bi == 1);
            start_b = (bi == 1);
            #1;
            if (b_if.m_axis_tvalid && b_if.pipe_en) begin
                if (bo < 2) begin
                    bu[bo] = b_if.m_axis_tuser;
                    bl[bo] = b_if.m_axis_tlast;
                    bd[bo] = b_if.m_axis_tdata;
                end
                bo++;
            end
            if (b_if.s_axis_tvalid && b_if.s_axis_tready) bi++;
            if (done_b) bdone = k;
        end
        start_b = 1'b0;
        b_if.s_axis_tvalid = 1'b0;
        chk("b_out_count", 128'(bo), 128'(2));
        chk("b_done_seen", 128'(bdone >= 0), 128'(1));
        chk("b_user0", 128'(bu[0]), 128'(2'b10));
        chk("b_user1", 128'(bu[1]), 128'(2'b11));
        chk("b_last", 128'({bl[0], bl[1]}), 128'(2'b01));
        chk("b_data0", bd[0], {96'h0, 32'hB000_0000});
        chk("b_data1", bd[1], {96'h0, 32'hB000_0001});
        chk("b_err", 128'(err_b), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
